timekeeper_core: RTL and testbench

Parametrised successor to the board clock's counter/flash path. It contains:
- a tick divider,
- a 24 h time-of-day counter,
- a button-driven set-mode FSM,
- 12/24 h display conversion with blink gating for the selected field.

It takes already-debounced one-cycle button pulses and feeds the seg7 decoders and the watch/debug outputs. An optional alarm comparator is included.

---
 rtl/timekeeper_core.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_timekeeper_core.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_core.sv
// timekeeper_core
//   Seconds divider, 24 h time-of-day counter, button-driven set-mode FSM and
//   12/24 h display path with blink gating of the field being edited.
//   Optional alarm comparator, built only when TIMEKEEPER_ALARM_EN is defined;
//   the port list is the same either way.
//
// Ports
//   clk_i                  system clock, rising edge
//   rst_ni                 synchronous active-low reset
//   set_time_i             pulse: enter/leave set mode
//   set_change_i           pulse: select next field in set mode
//   set_add_i              pulse: increment the selected field
//   mode_12h_i             1 = 12 h display, 0 = 24 h display
//   alarm_arm_i            alarm enable level
//   alarm_hour_i           alarm hour 0..23
//   alarm_min_i            alarm minute 0..59
//   hour_h_o .. second_l_o registered BCD display digits
//   hour_on_o, minute_on_o, second_on_o  per-field display enables
//   pm_o                   12 h mode and hour 12..23
//   set_active_o           set mode active
//   sec_pulse_o            one-cycle pulse per running second
//   alarm_ring_o           alarm indicator
module timekeeper_core #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned ALARM_SECS = 30
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_time_i,
    input  logic       set_change_i,
    input  logic       set_add_i,
    input  logic       mode_12h_i,
    input  logic       alarm_arm_i,
    input  logic [4:0] alarm_hour_i,
    input  logic [5:0] alarm_min_i,
    output logic [3:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [3:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic [3:0] second_h_o,
    output logic [3:0] second_l_o,
    output logic       hour_on_o,
    output logic       minute_on_o,
    output logic       second_on_o,
    output logic       pm_o,
    output logic       set_active_o,
    output logic       sec_pulse_o,
    output logic       alarm_ring_o
);

    localparam int unsigned DivW         = $clog2(CLK_HZ);
    localparam logic [DivW-1:0] DivMax   = DivW'(CLK_HZ - 1);
    localparam int unsigned BlinkHalfRaw = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BlinkHalf    = (BlinkHalfRaw == 0) ? 1 : BlinkHalfRaw;
    localparam int unsigned BlinkW       = (BlinkHalf > 1) ? $clog2(BlinkHalf) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkHalf - 1);

    typedef enum logic [1:0] {StRun, StSetHour, StSetMin, StSetSec} state_e;

    state_e state_q, state_d;

    logic [4:0]        hour_q, hour_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    logic in_set, sel_hour, sel_min, sel_sec;
    logic tick, btn_add;

    // Display output registers
    logic [3:0] hour_h_q, hour_l_q, minute_h_q, minute_l_q, second_h_q, second_l_q;
    logic       hour_on_q, minute_on_q, second_on_q;
    logic       pm_q, set_active_q, sec_pulse_q;
    logic [4:0] disp_hour;
    logic       pm_d;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // set_time outranks set_change; set_add never moves the FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (set_time_i) state_d = StSetHour;
            end
            StSetHour: begin
                if (set_time_i)        state_d = StRun;
                else if (set_change_i) state_d = StSetMin;
            end
            StSetMin: begin
                if (set_time_i)        state_d = StRun;
                else if (set_change_i) state_d = StSetSec;
            end
            StSetSec: begin
                if (set_time_i)        state_d = StRun;
                else if (set_change_i) state_d = StSetHour;
            end
            default: state_d = StRun;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_set   = 1'b1;
        sel_hour = 1'b0;
        sel_min  = 1'b0;
        sel_sec  = 1'b0;
        unique case (state_q)
            StRun:     in_set   = 1'b0;
            StSetHour: sel_hour = 1'b1;
            StSetMin:  sel_min  = 1'b1;
            StSetSec:  sel_sec  = 1'b1;
            default:   in_set   = 1'b0;
        endcase
    end

    // Lower-priority pulses are dropped when a higher one arrives together.
    assign btn_add = set_add_i & ~set_time_i & ~set_change_i;

    // ---------------- Divider and blink ----------------
    always_comb begin
        tick  = ~in_set & (div_q == DivMax);
        div_d = (in_set || tick) ? '0 : div_q + 1'b1;

        // Blink phase is parked at 1 in RUN so every set-mode entry starts visible.
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!in_set) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // ---------------- Time of day ----------------
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (btn_add) begin
            // Set-mode edits wrap within the field and never carry.
            if (sel_hour) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            if (sel_min)  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (sel_sec)  sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hour_q        <= '0;
            min_q         <= '0;
            sec_q         <= '0;
            div_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            hour_q        <= hour_d;
            min_q         <= min_d;
            sec_q         <= sec_d;
            div_q         <= div_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // ---------------- Display conversion ----------------
    always_comb begin
        disp_hour = hour_q;
        pm_d      = 1'b0;
        if (mode_12h_i) begin
            pm_d = (hour_q >= 5'd12);
            if (hour_q == 5'd0)       disp_hour = 5'd12;
            else if (hour_q > 5'd12)  disp_hour = hour_q - 5'd12;
        end
        hour_bcd = to_bcd({2'b00, disp_hour});
        min_bcd  = to_bcd({1'b0, min_q});
        sec_bcd  = to_bcd({1'b0, sec_q});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hour_h_q     <= '0;
            hour_l_q     <= '0;
            minute_h_q   <= '0;
            minute_l_q   <= '0;
            second_h_q   <= '0;
            second_l_q   <= '0;
            hour_on_q    <= 1'b1;
            minute_on_q  <= 1'b1;
            second_on_q  <= 1'b1;
            pm_q         <= 1'b0;
            set_active_q <= 1'b0;
            sec_pulse_q  <= 1'b0;
        end else begin
            hour_h_q     <= hour_bcd[7:4];
            hour_l_q     <= hour_bcd[3:0];
            minute_h_q   <= min_bcd[7:4];
            minute_l_q   <= min_bcd[3:0];
            second_h_q   <= sec_bcd[7:4];
            second_l_q   <= sec_bcd[3:0];
            hour_on_q    <= sel_hour ? blink_phase_q : 1'b1;
            minute_on_q  <= sel_min ? blink_phase_q : 1'b1;
            second_on_q  <= sel_sec ? blink_phase_q : 1'b1;
            pm_q         <= pm_d;
            set_active_q <= in_set;
            sec_pulse_q  <= tick;
        end
    end

    assign hour_h_o     = hour_h_q;
    assign hour_l_o     = hour_l_q;
    assign minute_h_o   = minute_h_q;
    assign minute_l_o   = minute_l_q;
    assign second_h_o   = second_h_q;
    assign second_l_o   = second_l_q;
    assign hour_on_o    = hour_on_q;
    assign minute_on_o  = minute_on_q;
    assign second_on_o  = second_on_q;
    assign pm_o         = pm_q;
    assign set_active_o = set_active_q;
    assign sec_pulse_o  = sec_pulse_q;

    // ---------------- Alarm ----------------
`ifdef TIMEKEEPER_ALARM_EN
    localparam int unsigned RingW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

    logic             ring_q, ring_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic             any_btn, alarm_match;

    always_comb begin
        any_btn     = set_time_i | set_change_i | set_add_i;
        // Compare against the time this tick is about to produce.
        alarm_match = tick && (hour_d == alarm_hour_i) && (min_d == alarm_min_i) &&
                      (sec_d == 6'd0);
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;
        if (!alarm_arm_i || any_btn) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_q) begin
            // A fresh match while ringing is ignored; only ticks shorten the ring.
            if (tick) begin
                if (ring_cnt_q == RingW'(1)) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q - 1'b1;
                end
            end
        end else if (alarm_match) begin
            ring_d     = 1'b1;
            ring_cnt_d = RingW'(ALARM_SECS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign alarm_ring_o = ring_q;
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_arm_i, alarm_hour_i, alarm_min_i};
    assign alarm_ring_o = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
module tb_timekeeper_core;

    localparam int unsigned CLK_HZ     = 10;
    localparam int unsigned BLINK_HZ   = 1;
    localparam int unsigned ALARM_SECS = 3;
    localparam int          HALF       = CLK_HZ / (2 * BLINK_HZ);
`ifdef TIMEKEEPER_ALARM_EN
    localparam bit          ALARM_ON   = 1'b1;
`else
    localparam bit          ALARM_ON   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_time = 1'b0, set_change = 1'b0, set_add = 1'b0;
    logic       mode_12h = 1'b0, alarm_arm = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic [3:0] hour_h, hour_l, minute_h, minute_l, second_h, second_l;
    logic       hour_on, minute_on, second_on, pm, set_active, sec_pulse, alarm_ring;

    timekeeper_core #(
        .CLK_HZ    (CLK_HZ),
        .BLINK_HZ  (BLINK_HZ),
        .ALARM_SECS(ALARM_SECS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .set_time_i  (set_time),
        .set_change_i(set_change),
        .set_add_i   (set_add),
        .mode_12h_i  (mode_12h),
        .alarm_arm_i (alarm_arm),
        .alarm_hour_i(alarm_hour),
        .alarm_min_i (alarm_min),
        .hour_h_o    (hour_h),
        .hour_l_o    (hour_l),
        .minute_h_o  (minute_h),
        .minute_l_o  (minute_l),
        .second_h_o  (second_h),
        .second_l_o  (second_l),
        .hour_on_o   (hour_on),
        .minute_on_o (minute_on),
        .second_on_o (second_on),
        .pm_o        (pm),
        .set_active_o(set_active),
        .sec_pulse_o (sec_pulse),
        .alarm_ring_o(alarm_ring)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time as seconds of day, mode 0=run 1=hour 2=min 3=sec.
    int m_secs, m_mode, m_div, m_set_cyc, m_ring_left;
    bit m_ring;
    int e_hh, e_hl, e_mh, e_ml, e_sh, e_sl;
    bit e_hon, e_mon, e_son, e_pm, e_set, e_pulse, e_ring;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int h, m, s, dh, new_secs;
        bit tick, btn, phase;
        if (!rst_n) begin
            m_secs = 0; m_mode = 0; m_div = 0; m_set_cyc = 0; m_ring = 0; m_ring_left = 0;
            e_hh = 0; e_hl = 0; e_mh = 0; e_ml = 0; e_sh = 0; e_sl = 0;
            e_hon = 1; e_mon = 1; e_son = 1;
            e_pm = 0; e_set = 0; e_pulse = 0; e_ring = 0;
            return;
        end
        h = m_secs / 3600;
        m = (m_secs / 60) % 60;
        s = m_secs % 60;
        dh = h;
        if (mode_12h) dh = (h % 12 == 0) ? 12 : h % 12;
        e_pm = mode_12h && (h >= 12);
        e_hh = dh / 10; e_hl = dh % 10;
        e_mh = m / 10;  e_ml = m % 10;
        e_sh = s / 10;  e_sl = s % 10;
        phase = (m_mode == 0) ? 1'b1 : (((m_set_cyc / HALF) % 2) == 0);
        e_hon = (m_mode == 1) ? phase : 1'b1;
        e_mon = (m_mode == 2) ? phase : 1'b1;
        e_son = (m_mode == 3) ? phase : 1'b1;
        e_set = (m_mode != 0);
        tick = (m_mode == 0) && (m_div == CLK_HZ - 1);
        e_pulse = tick;
        new_secs = tick ? (m_secs + 1) % 86400 : m_secs;
        btn = set_time | set_change | set_add;
        if (ALARM_ON) begin
            if (!alarm_arm || btn) m_ring = 0;
            else if (m_ring) begin
                if (tick) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_ring = 0;
                end
            end else if (tick && new_secs == alarm_hour * 3600 + alarm_min * 60) begin
                m_ring = 1;
                m_ring_left = ALARM_SECS;
            end
        end else begin
            m_ring = 0;
        end
        e_ring = m_ring;
        if (m_mode == 0) begin
            m_secs = new_secs;
            m_div = (m_div + 1) % CLK_HZ;
            m_set_cyc = 0;
            if (set_time) m_mode = 1;
        end else begin
            m_div = 0;
            m_set_cyc++;
            if (set_time) m_mode = 0;
            else if (set_change) m_mode = (m_mode == 3) ? 1 : m_mode + 1;
            else if (set_add) begin
                if (m_mode == 1) h = (h + 1) % 24;
                if (m_mode == 2) m = (m + 1) % 60;
                if (m_mode == 3) s = (s + 1) % 60;
                m_secs = h * 3600 + m * 60 + s;
            end
        end
    endtask

    task automatic check_all();
        chk("hour_h", hour_h, e_hh);
        chk("hour_l", hour_l, e_hl);
        chk("minute_h", minute_h, e_mh);
        chk("minute_l", minute_l, e_ml);
        chk("second_h", second_h, e_sh);
        chk("second_l", second_l, e_sl);
        chk("hour_on", hour_on, e_hon);
        chk("minute_on", minute_on, e_mon);
        chk("second_on", second_on, e_son);
        chk("pm", pm, e_pm);
        chk("set_active", set_active, e_set);
        chk("sec_pulse", sec_pulse, e_pulse);
        chk("alarm_ring", alarm_ring, e_ring);
    endtask

    task automatic step(input bit st, input bit sc, input bit sa);
        set_time = st; set_change = sc; set_add = sa;
        @(posedge clk);
        model_edge();
        #1;
        set_time = 0; set_change = 0; set_add = 0;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1;
    endtask

    int  p0, p1, p2, np, chg, zeros, ring_cycles, secs_t;
    bit  prev, st, sc, sa;

    initial begin
        // 1: reset state and free run
        do_reset();
        chk("rst_hour_l", hour_l, 0);
        chk("rst_hour_on", hour_on, 1);
        chk("rst_set_active", set_active, 0);
        p0 = -1; p1 = -1; p2 = -1; np = 0;
        for (int i = 1; i <= 31; i++) begin
            step(0, 0, 0);
            if (sec_pulse) begin
                if (np == 0) p0 = i;
                if (np == 1) p1 = i;
                if (np == 2) p2 = i;
                np++;
            end
        end
        chk("pulse_count", np, 3);
        chk("pulse_first", p0, 10);
        chk("pulse_gap1", p1 - p0, 10);
        chk("pulse_gap2", p2 - p1, 10);
        chk("run_second_l", second_l, 3);

        // 2: set 23:59:59 and roll over
        do_reset();
        step(1, 0, 0);
        repeat (23) step(0, 0, 1);
        step(0, 1, 0);
        repeat (59) step(0, 0, 1);
        step(0, 1, 0);
        repeat (59) step(0, 0, 1);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        chk("pre_wrap_hour_h", hour_h, 2);
        chk("pre_wrap_hour_l", hour_l, 3);
        chk("pre_wrap_second_l", second_l, 9);
        chk("wrap_pulse", sec_pulse, 1);
        step(0, 0, 0);
        chk("wrap_digits", {hour_h, hour_l, minute_h, minute_l, second_h, second_l}, 0);

        // 3: blink gating
        do_reset();
        step(1, 0, 0);
        chg = 0; zeros = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (i == 0) chk("blink_first_on", hour_on, 1);
            else if (hour_on != prev) chg++;
            prev = hour_on;
            if (!minute_on || !second_on) zeros++;
        end
        chk("blink_hour_toggles", chg, 3);
        chk("blink_others_on", zeros, 0);
        step(0, 1, 0);
        chg = 0; zeros = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (i != 0 && minute_on != prev) chg++;
            prev = minute_on;
            if (!hour_on) zeros++;
        end
        chk("blink_min_toggles", chg, 4);
        chk("blink_hour_steady", zeros, 0);
        step(1, 0, 0);

        // 4: simultaneous pulses, hour wrap without carry
        do_reset();
        step(1, 0, 1);
        step(0, 0, 0);
        chk("simul_hour", {hour_h, hour_l}, 0);
        chk("simul_set_active", set_active, 1);
        step(0, 1, 0);
        repeat (5) step(0, 0, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        repeat (23) step(0, 0, 1);
        step(0, 0, 0);
        chk("hour23", {hour_h, hour_l}, 8'h23);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("hour_wrap", {hour_h, hour_l}, 0);
        chk("hour_wrap_min", {minute_h, minute_l}, 8'h05);

        // 5: 12 h display
        do_reset();
        mode_12h = 1;
        step(1, 0, 0);
        step(0, 0, 0);
        chk("h12_0_digits", {hour_h, hour_l}, 8'h12);
        chk("h12_0_pm", pm, 0);
        repeat (13) step(0, 0, 1);
        step(0, 0, 0);
        chk("h12_13_digits", {hour_h, hour_l}, 8'h01);
        chk("h12_13_pm", pm, 1);
        repeat (23) step(0, 0, 1);
        step(0, 0, 0);
        chk("h12_12_digits", {hour_h, hour_l}, 8'h12);
        chk("h12_12_pm", pm, 1);
        mode_12h = 0;
        step(0, 0, 0);
        chk("h24_12_pm", pm, 0);
        step(1, 0, 0);

        // 6: alarm at 00:01 from 00:00:58
        alarm_hour = 0; alarm_min = 1; alarm_arm = 1;
        do_reset();
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
        repeat (58) step(0, 0, 1);
        step(1, 0, 0);
        ring_cycles = 0;
        repeat (60) begin
            step(0, 0, 0);
            if (alarm_ring) ring_cycles++;
        end
        chk("alarm_ring_len", ring_cycles, ALARM_ON ? 3 * CLK_HZ : 0);
        do_reset();
        step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
        repeat (58) step(0, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 40 && !alarm_ring; i++) step(0, 0, 0);
        chk("alarm_rise", alarm_ring, ALARM_ON);
        step(0, 0, 1);
        chk("alarm_cancel", alarm_ring, 0);

        // Random phase against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            st = ($urandom_range(0, 59) == 0);
            sc = (m_mode != 0) && ($urandom_range(0, 7) == 0);
            sa = (m_mode != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
            if ($urandom_range(0, 249) == 0) alarm_arm = ~alarm_arm;
            if ($urandom_range(0, 99) == 0) begin
                secs_t = (m_secs + 60 - (m_secs % 60)) % 86400;
                alarm_hour = 5'(secs_t / 3600);
                alarm_min = 6'((secs_t / 60) % 60);
            end
            rst_n = ($urandom_range(0, 799) != 0);
            step(st, sc, sa);
            rst_n = 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
